adc_sample_ctrl: RTL
====================

# adc_sample_ctrl

Sequencer for the on-chip 8-bit ADC. It generates `adc_clock` toward the analog shell from the digital clock using a programmable divider, and captures `adc_data` once per ADC period. It runs bursts of N samples or runs continuously, and buffers samples in a small FIFO with a ready/valid output toward the digital core. It sits inside `Digital`, between the `adc_clock`/`adc_data` boundary and the register/DMA logic.

## Interface
- `DIV_W`, 8: width of the divider config.
- `DEPTH`, 4: FIFO depth in samples. Power of two, ≥ 2.
- `clock`  in  1: sole clock. Both edges of `adc_clock` are derived from it.
- `reset`  in  1: asynchronous, active-high. Clears all state.
- `cfg_div`  in  DIV_W: `adc_clock` half-period equals `cfg_div`+1 clock cycles. Latched on accepted `start`.
- `cfg_count`  in  8: samples per burst. 0 means continuous. Latched on accepted `start`.
- `start`  in  1: single-cycle request to begin a run.
- `stop`  in  1: single-cycle request to end a run.
- `busy`  out  1: high whenever the state is not IDLE.
- `overflow`  out  1: sticky flag. Set when a sample is dropped. Cleared by accepted `start` or by `reset`.
- `adc_clock`  out  1: registered ADC clock. Glitch-free.
- `adc_data`  in  8: ADC result, stable around the falling edge of `adc_clock`.
- `out_valid`  out  1: FIFO is non-empty.
- `out_ready`  in  1: consumer accepts the head sample.
- `out_bits`  out  8: FIFO head sample.

## Operation
- States: IDLE, RUN, STOP.
- IDLE
  - `adc_clock`=0.
  - `start`=1 and `stop`=0: latch config, clear `overflow`, clear divider counter and sample counter, go to RUN.
  - `start` and `stop` both high: `stop` wins and the block stays in IDLE.
- RUN
  - The divider counter counts 0..cfg_div. On reaching cfg_div it wraps to 0 and `adc_clock` toggles.
  - Capture event: the edge at which `adc_clock` goes 1→0. `adc_data` sampled at that edge is pushed to the FIFO.
  - Every capture event increments the sample counter, whether or not the sample is dropped.
  - When the sample counter reaches `cfg_count` (with `cfg_count`≠0), go to IDLE on the same edge. `adc_clock` is already 0.
  - `stop` with `adc_clock`=0: go to IDLE next edge.
  - `stop` with `adc_clock`=1: go to STOP.
  - `start` is ignored in RUN.
- STOP
  - The divider keeps running until the high phase completes. That 1→0 transition is not captured. Then go to IDLE.
  - `start` and `stop` are ignored in STOP.
- FIFO
  - `out_valid`=!empty. `out_bits`=head.
  - Pop on `out_valid`&&`out_ready`.
  - Push while full with no pop: the sample is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both succeed and `overflow` is unchanged.
  - Pop while empty: no effect.
  - FIFO contents persist across runs. Only `reset` empties the FIFO.
- Sample counter is 8 bits. It is not compared in continuous mode and wraps freely.

## Timing
- Reset values: state IDLE, `busy`=0, `adc_clock`=0, `overflow`=0, `out_valid`=0, `out_bits`=0, all counters 0.
- Latencies from the edge that accepts `start`:
  - `busy`=1 after that edge.
  - First `adc_clock` rise after (cfg_div+1) cycles.
  - First capture at 2·(cfg_div+1) cycles.
  - The captured sample appears on `out_bits` with `out_valid`=1 one cycle after capture when the FIFO was empty.
- ADC period is 2·(cfg_div+1) cycles with a 50% duty cycle. The minimum period is 2 cycles.
- Burst completion: `busy` falls on the edge after the last capture, i.e. `busy` is low in the cycle following the final `adc_clock` fall.
- `reset` asserted mid-run: `adc_clock` goes to 0 immediately (asynchronous) and all outputs take their reset values.
- All outputs are registered except `out_valid` and `out_bits`, which are decoded from FIFO registers.

## Test plan
- Burst: cfg_div=0, cfg_count=3, `adc_data` = 0x10, 0x11, 0x12 at successive captures, `out_ready`=1. Required: `adc_clock` period 2, out sequence 0x10, 0x11, 0x12, `busy` high for 6 cycles, `overflow`=0.
- Overflow: DEPTH=4, cfg_count=6, `out_ready`=0. Required: 4 entries held (first four samples), `overflow`=1 after the 5th capture. A subsequent `start` clears `overflow` and FIFO data is retained.
- Stop during high phase: cfg_div=3, continuous. `stop` 2 cycles after an `adc_clock` rise. Required: `adc_clock` stays high 2 more cycles then falls, no extra FIFO entry, IDLE next cycle.
- Continuous mode with full-FIFO simultaneous push/pop: cfg_div=2, `out_ready` toggled so that a pop coincides with a capture while full. Required: period 6 cycles, no overflow, order preserved.
- Start/stop collision: `start` and `stop` in the same cycle in IDLE. Required: `busy` stays 0 and `adc_clock` stays 0.
- Reset mid-run: assert `reset` while `adc_clock`=1 with 2 samples queued. Required: `adc_clock`=0, `out_valid`=0, `busy`=0 immediately, before the next `clock` edge.

Source files
------------

// File: rtl/adc_sample_ctrl.sv
// adc_sample_ctrl: ADC sequencer. Divides clock down to adc_clock, captures
// adc_data on every adc_clock fall, runs N-sample bursts or continuously, and
// buffers samples in a small FIFO with a ready/valid output.
//
// Ports:
//   clock, reset         - sole clock; asynchronous active-high reset
//   cfg_div  [DIV_W]     - adc_clock half-period = cfg_div+1 cycles (latched on start)
//   cfg_count[8]         - samples per burst, 0 = continuous (latched on start)
//   start, stop          - single-cycle run control
//   busy                 - state is not IDLE
//   overflow             - sticky, a sample was dropped on a full FIFO
//   adc_clock            - registered ADC clock toward the analog shell
//   adc_data [8]         - ADC result, sampled on the adc_clock fall
//   out_valid/out_ready/out_bits[8] - FIFO head handshake
module adc_sample_ctrl #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [7:0]       cfg_count,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             overflow,
    output logic             adc_clock,
    input  logic [7:0]       adc_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_bits
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] r_cfg_div;
    logic [7:0]       r_cfg_count;
    logic [7:0]       r_smp_cnt;
    logic [7:0]       w_smp_inc;
    logic             r_adc_clk;
    logic             w_adc_clk_nxt;
    logic             r_busy;
    logic             r_overflow;
    logic             w_div_wrap;
    logic             w_capture;
    logic             w_start_acc;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_drop;

    assign w_div_wrap = (r_div_cnt == r_cfg_div);
    assign w_smp_inc  = 8'(r_smp_cnt + 8'd1);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, divider and capture decode
    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = r_div_cnt;
        w_adc_clk_nxt = r_adc_clk;
        w_capture     = 1'b0;
        w_start_acc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_adc_clk_nxt = 1'b0;
                w_div_nxt     = '0;
                if (start && !stop) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_div_wrap) begin
                    w_div_nxt     = '0;
                    w_adc_clk_nxt = !r_adc_clk;
                end else begin
                    w_div_nxt = DIV_W'(r_div_cnt + DIV_W'(1));
                end
                // A stop landing on the falling edge completes the high phase
                // right away, so that fall is not captured either.
                if (stop) begin
                    if (r_adc_clk && !w_div_wrap) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_state_nxt   = S_IDLE;
                        w_adc_clk_nxt = 1'b0;
                    end
                end else if (w_div_wrap && r_adc_clk) begin
                    w_capture = 1'b1;
                    if ((r_cfg_count != 8'd0) && (w_smp_inc == r_cfg_count)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_STOP: begin
                if (w_div_wrap) begin
                    w_div_nxt     = '0;
                    w_adc_clk_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_div_nxt = DIV_W'(r_div_cnt + DIV_W'(1));
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_adc_clk_nxt = 1'b0;
                w_div_nxt     = '0;
            end
        endcase
    end

    // Sequencer datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div_cnt   <= '0;
            r_cfg_div   <= '0;
            r_cfg_count <= 8'd0;
            r_smp_cnt   <= 8'd0;
            r_adc_clk   <= 1'b0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_adc_clk <= w_adc_clk_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            if (w_start_acc) begin
                r_cfg_div   <= cfg_div;
                r_cfg_count <= cfg_count;
                r_smp_cnt   <= 8'd0;
                r_overflow  <= 1'b0;
            end else begin
                if (w_capture) begin
                    r_smp_cnt <= w_smp_inc;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // FIFO: extra pointer bit separates full from empty
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                     (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
    assign w_pop   = !w_empty && out_ready;
    // Full with a simultaneous pop frees the head slot, so the push fits.
    assign w_drop  = w_capture && w_full && !w_pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= 8'd0;
            end
        end else begin
            if (w_capture && !w_drop) begin
                r_mem[r_wr_ptr[PTR_W-1:0]] <= adc_data;
                r_wr_ptr <= (PTR_W+1)'(r_wr_ptr + (PTR_W+1)'(1));
            end
            if (w_pop) begin
                r_rd_ptr <= (PTR_W+1)'(r_rd_ptr + (PTR_W+1)'(1));
            end
        end
    end

    assign busy      = r_busy;
    assign overflow  = r_overflow;
    assign adc_clock = r_adc_clk;
    assign out_valid = !w_empty;
    assign out_bits  = r_mem[r_rd_ptr[PTR_W-1:0]];

endmodule
